rv_instr_encoder: RTL and testbench
===================================

Name: rv_instr_encoder

Overview:
Sequential RV32I instruction encoder; the inverse of the core's opcode/func3/func7 control decoder.
- Accepts micro-op requests (instruction class, 4-bit ALU select in the core's alu_sel code space, register fields, immediate) over a valid/ready handshake.
- Encodes each legal request into a 32-bit instruction word and writes it to instruction memory at an auto-incrementing byte address, with memory backpressure.
- Used as the program loader/self-test generator in front of the imem.

Parameters:
ADDR_W, 12, byte-address width of imem_addr.
DEPTH, 1024, max words written before full asserts (DEPTH*4 <= 2**ADDR_W).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when req_valid && req_ready.
req_class  in  3  0=R, 1=I(ALU imm), 2=LOAD, 3=STORE, 4=BRANCH; 5-7 illegal.
req_alu_sel  in  4  ADD=0000 SUB=0001 SLL=0010 SLT=0011 SLTU=1000 XOR=0100 SRL=0101 OR=0110 AND=0111.
req_rd  in  5  destination register.
req_rs1  in  5  source register 1.
req_rs2  in  5  source register 2.
req_imm  in  12  I/S immediate; for BRANCH it is the byte offset bits [12:1].
base_load  in  1  load start address, flush, clear counters.
base_addr  in  ADDR_W  start byte address (bits[1:0] forced 0).
imem_we  out  1  write request; holds until imem_ready.
imem_ready  in  1  memory accepts the write when imem_we && imem_ready.
imem_addr  out  ADDR_W  byte address of the current write.
imem_wdata  out  32  encoded instruction.
full  out  1  DEPTH words written.
err  out  1  one-cycle pulse: the accepted request was illegal.
err_count  out  8  illegal requests, saturates at 255.

Behaviour:
- Reset values: req_ready=0 during reset; imem_we=0, imem_addr=0, imem_wdata=0, full=0, err=0, err_count=0, written-word count=0.
- Handshake: req_ready = !full && !base_load && (!imem_we || imem_ready). Output register pipeline, latency 1. A request accepted in cycle N gives imem_we=1 with valid data in cycle N+1, or err=1 in N+1 with no write. Back-to-back accepts sustain 1 word/clk while imem_ready=1.
- Stall: while imem_we && !imem_ready, imem_we, imem_addr and imem_wdata hold stable.
- Write completion (imem_we && imem_ready):
  - imem_addr += 4, wraps modulo 2**ADDR_W.
  - Count increments; full=1 when count reaches DEPTH.
  - imem_we drops unless a new request was accepted the same cycle.
- full is sticky until base_load or rst.
- Encoding:
  - R: opcode 0110011; func3 from alu_sel inverse map (ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL 101, OR 110, AND 111); func7=0100000 for SUB, else 0000000.
  - I: opcode 0010011, same func3. For SLL/SRL, bits[31:25]=0 and bits[24:20]=req_imm[4:0]; otherwise bits[31:20]=req_imm.
  - LOAD: LW; opcode 0000011, func3 010, I-format.
  - STORE: SW; opcode 0100011, func3 010, S-format, imm[11:5]->[31:25], imm[4:0]->[11:7].
  - BRANCH: BEQ; opcode 1100011, func3 000. req_imm[11]->31, req_imm[9:4]->30:25, req_imm[3:0]->11:8, req_imm[10]->7.
- Illegal requests: class 5-7; alu_sel not in map; I with SUB; LOAD/STORE with alu_sel!=ADD; BRANCH with alu_sel!=SUB. An illegal request is accepted (consumes the handshake), produces err pulse + err_count++, no write, no address advance.
- base_load: highest priority below rst.
  - Drops any pending word (imem_we=0 next cycle).
  - imem_addr={base_addr[ADDR_W-1:2],2'b00}; count=0, full=0; err_count unchanged.
  - A request presented the same cycle is not accepted.
- rst mid-stall: pending word discarded; all outputs return to reset values next cycle.

Test Plan:
- R encode: class0 ADD rd=3 rs1=1 rs2=2 -> cycle+1 imem_wdata=0x002081B3, imem_addr=0. SUB rd=5 rs1=6 rs2=7 -> 0x407302B3 at addr 4.
- I/LOAD/STORE/BRANCH: ADDI x1,x0,5 -> 0x00500093; LW x2,8(x1) -> 0x0080A103; SW x2,12(x1) -> 0x0020A623; BEQ x1,x2,+8 (req_imm=4) -> 0x00208463. Addresses 0,4,8,12.
- Backpressure: imem_ready=0 for 3 cycles with req_valid held -> imem_we/addr/wdata stable, req_ready=0. Release -> no word lost or duplicated, then 1 word/clk.
- Illegal: class I + SUB, then class 6 -> err pulses twice, err_count=2, imem_addr unchanged, no imem_we.
- Full/wrap: DEPTH=4, base_addr=0xFF8 with ADDR_W=12 -> writes at 0xFF8, 0xFFC, 0x000, 0x004. full=1 after the 4th write, req_ready=0. base_load clears full.
- Flush: base_load during stall -> imem_we=0 next cycle, imem_addr=base, pending word never written.

Source files
------------

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder
// ----------------
// Turns RV32I micro-op requests (class + alu_sel + register fields + immediate)
// back into 32-bit instruction words and streams them into instruction memory
// at an auto-incrementing byte address. It acts as the program loader /
// self-test generator in front of the imem.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake (accept = valid && ready)
//   req_class           0=R 1=I 2=LOAD 3=STORE 4=BRANCH, 5-7 illegal
//   req_alu_sel         core alu_sel code of the operation
//   req_rd/rs1/rs2      register fields
//   req_imm             I/S immediate, or BRANCH byte offset bits [12:1]
//   base_load/base_addr restart at a new word-aligned address, clear counters
//   imem_we/imem_ready  write handshake; the word holds until imem_ready
//   imem_addr/wdata     byte address and encoded instruction
//   full                DEPTH words written (sticky until base_load/rst)
//   err, err_count      illegal-request pulse and saturating count
module rv_instr_encoder #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_class,
    input  logic [3:0]        req_alu_sel,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [11:0]       req_imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [3:0] SEL_ADD = 4'b0000;
    localparam logic [3:0] SEL_SUB = 4'b0001;
    localparam logic [3:0] SEL_SLL = 4'b0010;
    localparam logic [3:0] SEL_SRL = 4'b0101;

    logic              imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              full_q,       full_d;
    logic              err_q,        err_d;
    logic [7:0]        err_count_q,  err_count_d;
    logic [CNT_W-1:0]  count_q,      count_d;

    logic        accept;
    logic        complete;
    logic [2:0]  func3;
    logic        sel_ok;
    logic        legal;
    logic [31:0] enc_word;

    // A new request can enter whenever the output register is empty or is
    // being drained this very cycle, which gives 1 word/clk when imem_ready=1.
    assign req_ready = !rst && !full_q && !base_load && (!imem_we_q || imem_ready);
    assign accept    = req_valid && req_ready;
    assign complete  = imem_we_q && imem_ready;

    // Inverse of the core's func3 -> alu_sel decode.
    always_comb begin
        sel_ok = 1'b1;
        func3  = 3'b000;
        case (req_alu_sel)
            4'b0000, 4'b0001: func3 = 3'b000;  // ADD / SUB
            4'b0010:          func3 = 3'b001;  // SLL
            4'b0011:          func3 = 3'b010;  // SLT
            4'b1000:          func3 = 3'b011;  // SLTU
            4'b0100:          func3 = 3'b100;  // XOR
            4'b0101:          func3 = 3'b101;  // SRL
            4'b0110:          func3 = 3'b110;  // OR
            4'b0111:          func3 = 3'b111;  // AND
            default:          sel_ok = 1'b0;
        endcase
    end

    always_comb begin
        legal    = 1'b0;
        enc_word = 32'h0;
        case (req_class)
            3'd0: begin  // R-type
                legal    = sel_ok;
                enc_word = {(req_alu_sel == SEL_SUB) ? 7'b0100000 : 7'b0000000,
                            req_rs2, req_rs1, func3, req_rd, 7'b0110011};
            end
            3'd1: begin  // I-type ALU; shifts carry a 5-bit shamt with zero upper bits
                legal = sel_ok && (req_alu_sel != SEL_SUB);
                if (req_alu_sel == SEL_SLL || req_alu_sel == SEL_SRL)
                    enc_word = {7'b0000000, req_imm[4:0], req_rs1, func3, req_rd, 7'b0010011};
                else
                    enc_word = {req_imm, req_rs1, func3, req_rd, 7'b0010011};
            end
            3'd2: begin  // LW
                legal    = (req_alu_sel == SEL_ADD);
                enc_word = {req_imm, req_rs1, 3'b010, req_rd, 7'b0000011};
            end
            3'd3: begin  // SW
                legal    = (req_alu_sel == SEL_ADD);
                enc_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], 7'b0100011};
            end
            3'd4: begin  // BEQ; req_imm already holds offset[12:1]
                legal    = (req_alu_sel == SEL_SUB);
                enc_word = {req_imm[11], req_imm[9:4], req_rs2, req_rs1, 3'b000,
                            req_imm[3:0], req_imm[10], 7'b1100011};
            end
            default: begin
                legal    = 1'b0;
                enc_word = 32'h0;
            end
        endcase
    end

    always_comb begin
        imem_we_d    = imem_we_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        full_d       = full_q;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
        count_d      = count_q;

        if (base_load) begin
            // Any pending word is discarded; err_count deliberately survives.
            imem_we_d   = 1'b0;
            imem_addr_d = base_addr & ~ADDR_W'(3);
            full_d      = 1'b0;
            count_d     = '0;
        end else begin
            if (complete) begin
                imem_addr_d = imem_addr_q + ADDR_W'(4);  // wraps modulo 2**ADDR_W
                if (count_q != CNT_W'(DEPTH))
                    count_d = count_q + CNT_W'(1);
                if (count_q >= CNT_W'(DEPTH - 1))
                    full_d = 1'b1;
            end

            if (accept && legal) begin
                imem_we_d    = 1'b1;
                imem_wdata_d = enc_word;
            end else if (complete) begin
                imem_we_d = 1'b0;
            end

            if (accept && !legal) begin
                err_d = 1'b1;
                if (err_count_q != 8'hFF)
                    err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            full_q       <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            count_q      <= '0;
        end else begin
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            full_q       <= full_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            count_q      <= count_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign full       = full_q;
    assign err        = err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Testbench for rv_instr_encoder: directed vectors, a cycle-level behavioural
// model compared every cycle, plus literal instruction words that pin the model.
module tb_rv_instr_encoder;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_class;
    logic [3:0]  req_alu_sel;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [11:0] req_imm;
    logic        base_load;
    logic [11:0] base_addr;
    logic        imem_we;
    logic        imem_ready;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        full;
    logic        err;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_class  (req_class),
        .req_alu_sel(req_alu_sel),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .base_load  (base_load),
        .base_addr  (base_addr),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .full       (full),
        .err        (err),
        .err_count  (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int alu_f3(input int sel);
        case (sel)
            0, 1: return 0;
            2:    return 1;
            3:    return 2;
            8:    return 3;
            4:    return 4;
            5:    return 5;
            6:    return 6;
            7:    return 7;
            default: return -1;
        endcase
    endfunction

    function automatic bit m_legal(input int cls, input int sel);
        case (cls)
            0:       return alu_f3(sel) >= 0;
            1:       return alu_f3(sel) >= 0 && sel != 1;
            2, 3:    return sel == 0;
            4:       return sel == 1;
            default: return 0;
        endcase
    endfunction

    // Field placement written from the RV32I formats with plain shifts.
    function automatic logic [31:0] m_enc(input int cls, input int sel, input int rd,
                                          input int rs1, input int rs2, input int imm);
        int w;
        int f3;
        int off;
        f3 = alu_f3(sel);
        w  = 0;
        case (cls)
            0: w = ((sel == 1) ? 32 : 0) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 'h33;
            1: if (sel == 2 || sel == 5)
                   w = (imm % 32) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 'h13;
               else
                   w = imm << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 'h13;
            2: w = imm << 20 | rs1 << 15 | 2 << 12 | rd << 7 | 'h03;
            3: w = (imm / 32) << 25 | rs2 << 20 | rs1 << 15 | 2 << 12 | (imm % 32) << 7 | 'h23;
            4: begin
                off = imm * 2;
                w = ((off >> 12) & 1) << 31 | ((off >> 5) & 63) << 25 | rs2 << 20 | rs1 << 15
                  | ((off >> 1) & 15) << 8 | ((off >> 11) & 1) << 7 | 'h63;
            end
            default: w = 0;
        endcase
        return 32'(w);
    endfunction

    bit          m_on = 0;
    bit          m_we, m_full, m_err;
    int          m_addr, m_words, m_errcnt;
    logic [31:0] m_wdata;

    function automatic bit m_ready();
        return !rst && !m_full && !base_load && (!m_we || imem_ready);
    endfunction

    always @(posedge clk) begin : model
        bit acc, done, ok;
        m_on = 1;
        if (rst) begin
            m_we = 0; m_addr = 0; m_wdata = 0; m_full = 0;
            m_err = 0; m_errcnt = 0; m_words = 0;
        end else begin
            acc  = req_valid && m_ready();
            done = m_we && imem_ready;
            ok   = m_legal(int'(req_class), int'(req_alu_sel));
            if (base_load) begin
                m_we = 0; m_addr = int'(base_addr) & 'hFFC;
                m_words = 0; m_full = 0; m_err = 0;
            end else begin
                m_err = acc && !ok;
                if (acc && !ok && m_errcnt < 255) m_errcnt++;
                if (done) begin
                    m_addr = (m_addr + 4) % 4096;
                    m_words++;
                    if (m_words >= DEPTH) m_full = 1;
                end
                if (acc && ok) begin
                    m_we = 1;
                    m_wdata = m_enc(int'(req_class), int'(req_alu_sel), int'(req_rd),
                                    int'(req_rs1), int'(req_rs2), int'(req_imm));
                end else if (done) begin
                    m_we = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("cyc_req_ready", 32'(req_ready), 32'(m_ready()));
            check("cyc_imem_we", 32'(imem_we), 32'(m_we));
            check("cyc_imem_addr", 32'(imem_addr), 32'(m_addr));
            if (m_we) check("cyc_imem_wdata", imem_wdata, m_wdata);
            check("cyc_full", 32'(full), 32'(m_full));
            check("cyc_err", 32'(err), 32'(m_err));
            check("cyc_err_count", 32'(err_count), 32'(m_errcnt));
        end
    end

    // ---------------- write log ----------------
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        if (!rst && !base_load && imem_we && imem_ready) begin
            log_addr.push_back(32'(imem_addr));
            log_data.push_back(imem_wdata);
            $display("write addr=0x%03h data=0x%08h", imem_addr, imem_wdata);
        end
    end

    task automatic check_log(input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx >= log_addr.size()) begin
            checks++;
            errors++;
            $display("FAIL log[%0d]: got no write expected addr 0x%0h data 0x%0h", idx, a, d);
        end else begin
            check($sformatf("log[%0d].addr", idx), log_addr[idx], a);
            check($sformatf("log[%0d].data", idx), log_data[idx], d);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int cls, input int sel, input int rd, input int rs1,
                       input int rs2, input int imm);
        req_valid   = 1'b1;
        req_class   = 3'(cls);
        req_alu_sel = 4'(sel);
        req_rd      = 5'(rd);
        req_rs1     = 5'(rs1);
        req_rs2     = 5'(rs2);
        req_imm     = 12'(imm);
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic load_base(input int a);
        base_load = 1'b1;
        base_addr = 12'(a);
        tick();
        base_load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_class = '0; req_alu_sel = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        base_load = 1'b0; base_addr = '0; imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_full", 32'(full), 0);
        check("rst_err_count", 32'(err_count), 0);
        rst = 1'b0;

        // R-type, latency 1
        put(0, 0, 3, 1, 2, 0); tick();
        check("add_we", 32'(imem_we), 1);
        check("add_data", imem_wdata, 32'h002081B3);
        check("add_addr", 32'(imem_addr), 0);
        put(0, 1, 5, 6, 7, 0); tick();
        check("sub_data", imem_wdata, 32'h407302B3);
        check("sub_addr", 32'(imem_addr), 4);
        idle(); tick(); tick();
        check_log(0, 32'h000, 32'h002081B3);
        check_log(1, 32'h004, 32'h407302B3);

        // I / LOAD / STORE / BRANCH
        load_base(0);
        put(1, 0, 1, 0, 0, 5);  tick();   // ADDI x1,x0,5
        put(2, 0, 2, 1, 0, 8);  tick();   // LW x2,8(x1)
        put(3, 0, 0, 1, 2, 12); tick();   // SW x2,12(x1)
        put(4, 1, 0, 1, 2, 4);  tick();   // BEQ x1,x2,+8
        idle(); tick(); tick();
        check_log(2, 32'h000, 32'h00500093);
        check_log(3, 32'h004, 32'h0080A103);
        check_log(4, 32'h008, 32'h0020A623);
        check_log(5, 32'h00C, 32'h00208463);
        check("full_after4", 32'(full), 1);

        // Backpressure
        load_base(12'h100);
        imem_ready = 1'b0;
        put(0, 4, 10, 11, 12, 0); tick();
        put(1, 5, 9, 8, 0, 12'hFE3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ready", 32'(req_ready), 0);
            check("stall_we", 32'(imem_we), 1);
            check("stall_addr", 32'(imem_addr), 32'h100);
            check("stall_data", imem_wdata, m_enc(0, 4, 10, 11, 12, 0));
        end
        imem_ready = 1'b1;
        tick();
        put(0, 3, 1, 2, 3, 0);      tick();
        put(1, 8, 4, 5, 0, 12'h7FF); tick();
        idle(); tick(); tick();
        check_log(6, 32'h100, m_enc(0, 4, 10, 11, 12, 0));
        check_log(7, 32'h104, m_enc(1, 5, 9, 8, 0, 12'hFE3));
        check_log(8, 32'h108, m_enc(0, 3, 1, 2, 3, 0));
        check_log(9, 32'h10C, m_enc(1, 8, 4, 5, 0, 12'h7FF));
        check("srli_shamt_only", m_enc(1, 5, 9, 8, 0, 12'hFE3), 32'h00345493);
        check("bp_log_size", 32'(log_addr.size()), 10);

        // Illegal requests
        load_base(12'h043);
        put(1, 1, 1, 1, 1, 1); tick();
        check("ill1_err", 32'(err), 1);
        check("ill1_cnt", 32'(err_count), 1);
        check("ill1_we", 32'(imem_we), 0);
        check("ill1_addr", 32'(imem_addr), 32'h040);
        put(6, 0, 1, 1, 1, 1); tick();
        check("ill2_err", 32'(err), 1);
        check("ill2_cnt", 32'(err_count), 2);
        check("ill2_we", 32'(imem_we), 0);
        check("ill2_addr", 32'(imem_addr), 32'h040);
        idle(); tick();
        check("ill_err_pulse", 32'(err), 0);

        // Full and address wrap
        load_base(12'hFFA);
        for (int i = 0; i < 4; i++) begin
            put(0, 6, i + 1, i + 2, i + 3, 0); tick();
        end
        idle(); tick(); tick();
        check_log(10, 32'hFF8, m_enc(0, 6, 1, 2, 3, 0));
        check_log(11, 32'hFFC, m_enc(0, 6, 2, 3, 4, 0));
        check_log(12, 32'h000, m_enc(0, 6, 3, 4, 5, 0));
        check_log(13, 32'h004, m_enc(0, 6, 4, 5, 6, 0));
        check("wrap_full", 32'(full), 1);
        put(0, 0, 1, 1, 1, 0); #1;
        check("full_ready", 32'(req_ready), 0);
        tick();
        idle();
        load_base(0);
        check("bl_clears_full", 32'(full), 0);
        check("wrap_log_size", 32'(log_addr.size()), 14);

        // Flush during stall
        load_base(12'h080);
        imem_ready = 1'b0;
        put(0, 7, 9, 9, 9, 0); tick();
        idle();
        check("flush_pre_we", 32'(imem_we), 1);
        base_load = 1'b1; base_addr = 12'h300; tick();
        base_load = 1'b0;
        check("flush_we", 32'(imem_we), 0);
        check("flush_addr", 32'(imem_addr), 32'h300);
        imem_ready = 1'b1;
        tick(); tick();
        check("flush_log_size", 32'(log_addr.size()), 14);

        // Reset mid-stall
        imem_ready = 1'b0;
        put(0, 0, 2, 2, 2, 0); tick();
        idle();
        check("rst2_pre_we", 32'(imem_we), 1);
        rst = 1'b1; tick();
        check("rst2_we", 32'(imem_we), 0);
        check("rst2_addr", 32'(imem_addr), 0);
        check("rst2_wdata", imem_wdata, 0);
        check("rst2_err_count", 32'(err_count), 0);
        check("rst2_ready", 32'(req_ready), 0);
        rst = 1'b0; imem_ready = 1'b1;
        tick(); tick();
        check("rst2_log_size", 32'(log_addr.size()), 14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
